// File: rtl/icap_reg_reader.sv
// icap_reg_reader: reads one Spartan-6 configuration register through ICAP.
// Sequence: sync header + type-1 read command, turnaround, readback wait,
// turnaround, desync trailer, one-cycle done pulse.
// Optional macro ICAP_RD_TIMEOUT_EN: abort RD_WAIT after TIMEOUT_CYC cycles
// and report err with done; without it RD_WAIT waits for icap_busy=0 forever.
module icap_reg_reader #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [5:0]  reg_addr,
    output logic        busy_o,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_i,
    input  logic [15:0] icap_o,
    input  logic        icap_busy
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_HDR   = 3'd1,
        TURN_RD  = 3'd2,
        RD_WAIT  = 3'd3,
        TURN_WR  = 3'd4,
        WR_DSYNC = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [5:0]         addr_q, addr_nxt;
    logic               accept;
    logic               capture;
    logic               timeout;

    logic               ce_n_d;
    logic               write_n_d;
    logic [DATA_W-1:0]  icap_i_d;
    logic               busy_d;
    logic               done_d;

`ifdef ICAP_RD_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt;
    logic       tout_q;
`else
    logic unused_timeout;
    assign unused_timeout = &{1'b0, 8'(TIMEOUT_CYC)};
`endif

    // Header word for index i; index 4 is the type-1 read of register a.
    function automatic logic [DATA_W-1:0] hdr_word(input logic [IDX_W-1:0] i,
                                                   input logic [5:0] a);
        case (i)
            3'd0:    hdr_word = 16'hFFFF;
            3'd1:    hdr_word = 16'hAA99;
            3'd2:    hdr_word = 16'h5566;
            3'd4:    hdr_word = {3'b001, 2'b01, a, 5'b00001};
            default: hdr_word = 16'h2000;
        endcase
    endfunction

    // Desync trailer word for index i.
    function automatic logic [DATA_W-1:0] dsync_word(input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    dsync_word = 16'h30A1;
            3'd1:    dsync_word = 16'h000D;
            default: dsync_word = 16'h2000;
        endcase
    endfunction

    // State register plus datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            addr_q       <= '0;
            icap_ce_n    <= 1'b1;
            icap_write_n <= 1'b0;
            icap_i       <= 16'hFFFF;
            busy_o       <= 1'b0;
            done         <= 1'b0;
            rdata        <= '0;
            err          <= 1'b0;
`ifdef ICAP_RD_TIMEOUT_EN
            wait_cnt     <= '0;
            tout_q       <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            addr_q       <= addr_nxt;
            icap_ce_n    <= ce_n_d;
            icap_write_n <= write_n_d;
            icap_i       <= icap_i_d;
            busy_o       <= busy_d;
            done         <= done_d;
            if (capture) begin
                rdata <= icap_o;
            end
`ifdef ICAP_RD_TIMEOUT_EN
            wait_cnt <= (state == RD_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (accept) begin
                tout_q <= 1'b0;
                err    <= 1'b0;
            end else begin
                if (timeout) begin
                    tout_q <= 1'b1;
                end
                if (state_nxt == DONE && tout_q) begin
                    err <= 1'b1;
                end
            end
`else
            err <= 1'b0;
`endif
        end
    end

    // Next-state, sequence index and capture decisions.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        addr_nxt  = addr_q;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = WR_HDR;
                    idx_nxt   = '0;
                    addr_nxt  = reg_addr;
                end
            end
            WR_HDR: begin
                if (idx == IDX_W'(6)) begin
                    state_nxt = TURN_RD;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            TURN_RD: begin
                if (idx == IDX_W'(1)) begin
                    state_nxt = RD_WAIT;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            RD_WAIT: begin
                // idx marks that the first (ignored) RD_WAIT cycle has passed
                idx_nxt = IDX_W'(1);
                if (idx != '0 && !icap_busy) begin
                    capture   = 1'b1;
                    state_nxt = TURN_WR;
                    idx_nxt   = '0;
                end
`ifdef ICAP_RD_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = TURN_WR;
                    idx_nxt   = '0;
                end
`endif
            end
            TURN_WR: begin
                if (idx == IDX_W'(1)) begin
                    state_nxt = WR_DSYNC;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            WR_DSYNC: begin
                if (idx == IDX_W'(3)) begin
                    state_nxt = DONE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming state, registered on the same edge.
    always_comb begin
        ce_n_d    = 1'b1;
        write_n_d = 1'b0;
        icap_i_d  = 16'hFFFF;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_nxt)
            WR_HDR: begin
                ce_n_d   = 1'b0;
                icap_i_d = hdr_word(idx_nxt, addr_nxt);
                busy_d   = 1'b1;
            end
            TURN_RD: begin
                write_n_d = (idx_nxt == IDX_W'(1));
                busy_d    = 1'b1;
            end
            RD_WAIT: begin
                ce_n_d    = 1'b0;
                write_n_d = 1'b1;
                busy_d    = 1'b1;
            end
            TURN_WR: begin
                write_n_d = (idx_nxt == IDX_W'(0));
                busy_d    = 1'b1;
            end
            WR_DSYNC: begin
                ce_n_d   = 1'b0;
                icap_i_d = dsync_word(idx_nxt);
                busy_d   = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icap_reg_reader.sv
// Directed testbench for icap_reg_reader.
module tb_icap_reg_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [5:0]  reg_addr = '0;
    logic        busy_o;
    logic        done;
    logic [15:0] rdata;
    logic        err;
    logic        icap_ce_n;
    logic        icap_write_n;
    logic [15:0] icap_i;
    logic [15:0] icap_o = '0;
    logic        icap_busy = 1'b0;

    icap_reg_reader #(.TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst(rst), .req(req), .reg_addr(reg_addr),
        .busy_o(busy_o), .done(done), .rdata(rdata), .err(err),
        .icap_ce_n(icap_ce_n), .icap_write_n(icap_write_n), .icap_i(icap_i),
        .icap_o(icap_o), .icap_busy(icap_busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_dones = 0;
    int          done_count = 0;
    int          wn_viol = 0;
    logic [15:0] words[$];
    logic        prev_ce = 1'b1;
    logic        prev_wn = 1'b0;

    // Bus monitor: collects written words, counts done pulses, flags write_n toggles under CE.
    always @(negedge clk) begin
        if (!rst) begin
            if (icap_ce_n == 1'b0 && icap_write_n == 1'b0) words.push_back(icap_i);
            if (done === 1'b1) done_count++;
            if ((prev_ce == 1'b0 || icap_ce_n == 1'b0) && icap_write_n !== prev_wn) begin
                wn_viol++;
                $display("FAIL wn_toggle_under_ce at %0t: write_n %b -> %b", $time, prev_wn, icap_write_n);
            end
        end
        prev_ce = icap_ce_n;
        prev_wn = icap_write_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one req and runs until the done cycle; busy_cyc = RD_WAIT cycles with icap_busy high.
    task automatic run_txn(input logic [5:0] a, input int busy_cyc, input logic [15:0] od,
                           input bit poke, output int lat, output logic busy_first);
        int rd;
        words.delete();
        icap_o    = od;
        icap_busy = 1'b0;
        reg_addr  = a;
        req       = 1'b1;
        tick();
        req        = 1'b0;
        busy_first = busy_o;
        lat = 0;
        rd  = 0;
        while (done !== 1'b1 && lat < 400) begin
            if (icap_ce_n == 1'b0 && icap_write_n == 1'b1) begin
                rd++;
                icap_busy = (rd <= busy_cyc);
                req       = poke && (rd == 1);
            end else begin
                icap_busy = 1'b0;
                req       = 1'b0;
            end
            tick();
            lat++;
        end
        req       = 1'b0;
        icap_busy = 1'b0;
        exp_dones++;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL txn_done_wait: done=%b after %0d cycles, required 1", done, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (icap_ce_n !== 1'b1)      begin n_bad++; $display("FAIL rst_ce_n: got %b want 1", icap_ce_n); end
        n_cmp++; if (icap_write_n !== 1'b0)   begin n_bad++; $display("FAIL rst_write_n: got %b want 0", icap_write_n); end
        n_cmp++; if (icap_i !== 16'hFFFF)     begin n_bad++; $display("FAIL rst_icap_i: got %h want FFFF", icap_i); end
        n_cmp++; if (busy_o !== 1'b0)         begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_cmp++; if (done !== 1'b0)           begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0)            begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (rdata !== 16'h0000)      begin n_bad++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        int          lat;
        logic        bf;
        logic [15:0] exp_w[11];
        exp_w = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h2901, 16'h2000, 16'h2000,
                  16'h30A1, 16'h000D, 16'h2000, 16'h2000};
        run_txn(6'h08, 0, 16'h1234, 1'b0, lat, bf);
        n_cmp++; if (bf !== 1'b1)         begin n_bad++; $display("FAIL basic_busy_first: got %b want 1", bf); end
        n_cmp++; if (lat !== 17)          begin n_bad++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_cmp++; if (busy_o !== 1'b1)     begin n_bad++; $display("FAIL basic_busy_done: got %b want 1", busy_o); end
        n_cmp++; if (rdata !== 16'h1234)  begin n_bad++; $display("FAIL basic_rdata: got %h want 1234", rdata); end
        n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL basic_err: got %b want 0", err); end
        n_cmp++; if (icap_ce_n !== 1'b1 || icap_write_n !== 1'b0 || icap_i !== 16'hFFFF) begin
            n_bad++; $display("FAIL basic_done_pins: got ce_n=%b wn=%b i=%h want 1 0 FFFF", icap_ce_n, icap_write_n, icap_i);
        end
        n_cmp++;
        if (words.size() !== 11) begin
            n_bad++; $display("FAIL basic_word_count: got %0d want 11", words.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_cmp++;
                if (words[i] !== exp_w[i]) begin
                    n_bad++; $display("FAIL basic_word[%0d]: got %h want %h", i, words[i], exp_w[i]);
                end
            end
        end
        tick();
        n_cmp++; if (done !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy_o);
        end
    endtask

    task automatic test_busy_wait();
        int   lat;
        logic bf;
        run_txn(6'h08, 10, 16'hBEEF, 1'b0, lat, bf);
        n_cmp++; if (lat !== 26)          begin n_bad++; $display("FAIL busy_latency: got %0d want 26", lat); end
        n_cmp++; if (rdata !== 16'hBEEF)  begin n_bad++; $display("FAIL busy_rdata: got %h want BEEF", rdata); end
        n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL busy_err: got %b want 0", err); end
        n_cmp++; if (words.size() !== 11) begin n_bad++; $display("FAIL busy_word_count: got %0d want 11", words.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   dc;
        logic bf;
        reg_addr = 6'h08;
        req      = 1'b1;
        tick();
        req = 1'b0;
        repeat (4) tick();
        n_cmp++; if (icap_i !== 16'h2901) begin n_bad++; $display("FAIL mid_idx4_word: got %h want 2901", icap_i); end
        dc  = done_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (icap_ce_n !== 1'b1)  begin n_bad++; $display("FAIL mid_ce_n: got %b want 1", icap_ce_n); end
        n_cmp++; if (busy_o !== 1'b0)     begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy_o); end
        n_cmp++; if (icap_i !== 16'hFFFF) begin n_bad++; $display("FAIL mid_icap_i: got %h want FFFF", icap_i); end
        n_cmp++; if (rdata !== 16'h0000)  begin n_bad++; $display("FAIL mid_rdata: got %h want 0000", rdata); end
        words.delete();
        repeat (20) tick();
        n_cmp++; if (words.size() !== 0)  begin n_bad++; $display("FAIL mid_no_desync: got %0d words want 0", words.size()); end
        n_cmp++; if (done_count !== dc)   begin n_bad++; $display("FAIL mid_no_done: got %0d dones want %0d", done_count, dc); end
        run_txn(6'h3F, 0, 16'h5A5A, 1'b0, lat, bf);
        n_cmp++; if (lat !== 17)          begin n_bad++; $display("FAIL mid_restart_latency: got %0d want 17", lat); end
        n_cmp++;
        if (words.size() !== 11) begin
            n_bad++; $display("FAIL mid_restart_count: got %0d want 11", words.size());
        end else begin
            n_cmp++; if (words[0] !== 16'hFFFF) begin n_bad++; $display("FAIL mid_restart_w0: got %h want FFFF", words[0]); end
            n_cmp++; if (words[4] !== 16'h2FE1) begin n_bad++; $display("FAIL mid_restart_hdr: got %h want 2FE1", words[4]); end
        end
        n_cmp++; if (rdata !== 16'h5A5A)  begin n_bad++; $display("FAIL mid_restart_rdata: got %h want 5A5A", rdata); end
        tick();
    endtask

    task automatic test_ignored_req();
        int   lat;
        logic bf;
        run_txn(6'h15, 0, 16'hC0DE, 1'b1, lat, bf);
        n_cmp++; if (lat !== 17)          begin n_bad++; $display("FAIL ign_latency: got %0d want 17", lat); end
        n_cmp++; if (words.size() !== 11 || words[4] !== 16'h2AA1) begin
            n_bad++; $display("FAIL ign_hdr: got %0d words hdr=%h want 11 2AA1", words.size(), words[4]);
        end
        n_cmp++; if (rdata !== 16'hC0DE)  begin n_bad++; $display("FAIL ign_rdata: got %h want C0DE", rdata); end
        req = 1'b1;
        tick();
        req = 1'b0;
        n_cmp++; if (busy_o !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL ign_done_req: got busy=%b done=%b want 0 0", busy_o, done);
        end
        repeat (3) tick();
        n_cmp++; if (busy_o !== 1'b0 || icap_ce_n !== 1'b1) begin
            n_bad++; $display("FAIL ign_stays_idle: got busy=%b ce_n=%b want 0 1", busy_o, icap_ce_n);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic bf;
        run_txn(6'h01, 0, 16'h0F0F, 1'b0, lat, bf);
        n_cmp++; if (rdata !== 16'h0F0F)  begin n_bad++; $display("FAIL b2b_rdata0: got %h want 0F0F", rdata); end
        tick();
        run_txn(6'h20, 2, 16'hF00F, 1'b0, lat, bf);
        n_cmp++; if (lat !== 18)          begin n_bad++; $display("FAIL b2b_latency1: got %0d want 18", lat); end
        n_cmp++; if (words.size() !== 11 || words[4] !== 16'h2C01) begin
            n_bad++; $display("FAIL b2b_hdr1: got %0d words hdr=%h want 11 2C01", words.size(), words[4]);
        end
        n_cmp++; if (rdata !== 16'hF00F)  begin n_bad++; $display("FAIL b2b_rdata1: got %h want F00F", rdata); end
        tick();
    endtask

`ifdef ICAP_RD_TIMEOUT_EN
    task automatic test_timeout();
        int   lat;
        logic bf;
        run_txn(6'h02, 0, 16'h7777, 1'b0, lat, bf);
        n_cmp++; if (rdata !== 16'h7777)  begin n_bad++; $display("FAIL to_pre_rdata: got %h want 7777", rdata); end
        tick();
        run_txn(6'h02, 100000, 16'hDEAD, 1'b0, lat, bf);
        n_cmp++; if (lat !== 270)         begin n_bad++; $display("FAIL to_latency: got %0d want 270", lat); end
        n_cmp++; if (err !== 1'b1)        begin n_bad++; $display("FAIL to_err: got %b want 1", err); end
        n_cmp++; if (rdata !== 16'h7777)  begin n_bad++; $display("FAIL to_rdata_kept: got %h want 7777", rdata); end
        n_cmp++; if (words.size() !== 11 || words[7] !== 16'h30A1) begin
            n_bad++; $display("FAIL to_desync: got %0d words w7=%h want 11 30A1", words.size(), words[7]);
        end
        tick();
        run_txn(6'h02, 0, 16'h1111, 1'b0, lat, bf);
        n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL to_err_cleared: got %b want 0", err); end
        tick();
    endtask
`endif

    task automatic test_bus_rules();
        repeat (2) tick();
        n_cmp++; if (wn_viol !== 0)       begin n_bad++; $display("FAIL wn_rule: got %0d toggles want 0", wn_viol); end
        n_cmp++; if (done_count !== exp_dones) begin
            n_bad++; $display("FAIL done_count: got %0d want %0d", done_count, exp_dones);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_busy_wait();
        test_reset_mid();
        test_ignored_req();
        test_back_to_back();
`ifdef ICAP_RD_TIMEOUT_EN
        test_timeout();
`endif
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icap_reg_reader.md
ICAP_REG_READER -- requirements
Module: icap_reg_reader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning max RD_WAIT cycles before abort (8-bit counter).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  start pulse; sampled only in IDLE.
REQ-005 SHALL have port reg_addr  input  6  config register address; captured on accepted req.
REQ-006 SHALL have port busy_o  output  1  high from cycle after accepted req until DONE cycle inclusive.
REQ-007 SHALL have port done  output  1  one-cycle pulse at end of transaction.
REQ-008 SHALL have port rdata  output  16  last captured register word; held until next capture.
REQ-009 SHALL have port err  output  1  set with done when read timed out; cleared on next accepted req.
REQ-010 SHALL have ports icap_ce_n  output  1, icap_write_n  output  1, icap_i  output  16  (active-low ICAP_SPARTAN6 CE/WRITE, write data).
REQ-011 SHALL have ports icap_o  input  16, icap_busy  input  1  (ICAP readback data and BUSY).

Function
REQ-012 SHALL implement states IDLE, WR_HDR, TURN_RD, RD_WAIT, TURN_WR, WR_DSYNC, DONE.
REQ-013 IDLE: icap_ce_n=1, icap_write_n=0, icap_i=16'hFFFF; req=1 -> WR_HDR, index 0, latch reg_addr, clear err.
REQ-014 WR_HDR: icap_ce_n=0, icap_write_n=0, one word per cycle, index 0..6: FFFF, AA99, 5566, 2000, {3'b001,2'b01,reg_addr,5'b00001}, 2000, 2000; after index 6 -> TURN_RD.
REQ-015 Header arithmetic: word = 16'h2801 | (reg_addr<<5); reg_addr 6'h08 -> 16'h2901, 6'h3F -> 16'h2FE1.
REQ-016 TURN_RD: 2 cycles, icap_ce_n=1; write_n=0 first cycle, 1 second; -> RD_WAIT.
REQ-017 RD_WAIT: icap_ce_n=0, icap_write_n=1; from 2nd RD_WAIT cycle on, first edge with icap_busy=0 captures icap_o into rdata -> TURN_WR.
REQ-018 TURN_WR: 2 cycles, icap_ce_n=1; write_n=1 first cycle, 0 second; -> WR_DSYNC.
REQ-019 WR_DSYNC: icap_ce_n=0, icap_write_n=0, index 0..3: 30A1, 000D, 2000, 2000; -> DONE.
REQ-020 DONE: one cycle, done=1, ICAP pins as IDLE; -> IDLE.
REQ-021 icap_write_n SHALL never change in a cycle where icap_ce_n=0.
REQ-022 req outside IDLE SHALL be ignored, not queued; req in DONE cycle ignored.
REQ-023 Minimum transaction latency req -> done = 17 cycles (busy already low at 2nd RD_WAIT cycle).
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst SHALL force IDLE and icap_ce_n=1, icap_write_n=0, icap_i=16'hFFFF, busy_o=0, done=0, err=0, rdata=0, counters 0, on the same edge.
REQ-026 rst mid-transaction SHALL abort without desync words; next req restarts full sequence from index 0.
REQ-027 rst has priority over req on the same edge.

Configuration
REQ-028 Macro ICAP_RD_TIMEOUT_EN defined: RD_WAIT counts cycles; at TIMEOUT_CYC cycles without capture -> err=1, rdata unchanged, -> TURN_WR (desync still sent), done with err=1.
REQ-029 Macro undefined: no counter, err tied 0, RD_WAIT waits indefinitely for icap_busy=0.

Verification
REQ-030 req, reg_addr=6'h08, busy low, icap_o=16'h1234 -> icap_i sequence FFFF,AA99,5566,2000,2901,2000,2000 then 30A1,000D,2000,2000; rdata=1234, done at req+17, err=0.
REQ-031 icap_busy held high 10 RD_WAIT cycles, icap_o=16'hBEEF when released -> rdata=BEEF, done delayed 9 cycles vs REQ-030, err=0.
REQ-032 With ICAP_RD_TIMEOUT_EN, icap_busy stuck high -> after 255 RD_WAIT cycles desync words sent, done=1, err=1, rdata retains previous value.
REQ-033 rst asserted during WR_HDR index 4 -> next edge icap_ce_n=1, busy_o=0, IDLE; subsequent req with 6'h3F emits header 2FE1.
REQ-034 req pulsed during RD_WAIT and in DONE cycle -> ignored; exactly one done per accepted req; checker flags any write_n toggle with ce_n=0.
